// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and stall/flush patterns for pipe_ctrl
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_MDU_WAIT = 2'd3
  } state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  // Flush bit n bubbles the register that follows stage n.
  localparam logic [3:0] FLUSH_INIT = 4'b1111;
  localparam logic [3:0] STALL_TRAP = 4'b0000;
  localparam logic [3:0] FLUSH_TRAP = (4'b1 << STG_IF) | (4'b1 << STG_ID) | (4'b1 << STG_EX);
  localparam logic [3:0] STALL_MEMW = 4'b1111;
  localparam logic [3:0] FLUSH_MEMW = 4'b1 << STG_MEM;
  localparam logic [3:0] STALL_MDUW = 4'b0111;
  localparam logic [3:0] FLUSH_MDUW = 4'b1 << STG_EX;
  localparam logic [3:0] STALL_BR   = 4'b0000;
  localparam logic [3:0] FLUSH_BR   = (4'b1 << STG_IF) | (4'b1 << STG_ID);
  localparam logic [3:0] STALL_LU   = 4'b0011;
  localparam logic [3:0] FLUSH_LU   = 4'b1 << STG_ID;

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_MEM_WAIT) || (s == ST_MDU_WAIT);
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// rtl/pipe_ctrl_wdog.sv - saturating stall watchdog; expires on the TIMEOUT_MAX-th enabled cycle
module pipe_ctrl_wdog #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TIMEOUT_W-1:0] LP_MAX  = TIMEOUT_W'(TIMEOUT_MAX);
  localparam logic [TIMEOUT_W-1:0] LP_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect sequencer
// Optional perf counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 200
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_use_i,
  input  logic            mdu_start_i,
  input  logic            mdu_done_i,
  input  logic            dmem_req_i,
  input  logic            dmem_ready_i,
  input  logic            br_mispredict_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [3:0]      stall_o,
  output logic [3:0]      flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            dmem_abort_o,
  output logic            timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_o,
  output logic [31:0]     perf_flush_o,
  output logic [31:0]     perf_lu_o
`endif
);

  state_e          r_state;
  state_e          w_next;
  logic            r_pend_br;
  logic [XLEN-1:0] r_br_tgt;
  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_timeout;

  logic w_trap;
  logic w_br;
  logic w_lu;
  logic w_latch_br;
  logic w_wait;
  logic w_expire;

  assign w_wait = is_wait_state(r_state);

  pipe_ctrl_wdog #(
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT_MAX(TIMEOUT_MAX)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (!w_wait),
    .i_en    (w_wait),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = ST_RUN;
    stall_o      = '0;
    flush_o      = '0;
    dmem_abort_o = 1'b0;
    w_trap       = 1'b0;
    w_br         = 1'b0;
    w_lu         = 1'b0;
    w_latch_br   = 1'b0;

    if (r_state == ST_INIT) begin
      flush_o = FLUSH_INIT;
    end else if (trap_i) begin
      w_trap       = 1'b1;
      stall_o      = STALL_TRAP;
      flush_o      = FLUSH_TRAP;
      dmem_abort_o = dmem_req_i;
    end else if (((r_state == ST_RUN) && dmem_req_i && !dmem_ready_i) ||
                 ((r_state == ST_MEM_WAIT) && !dmem_ready_i)) begin
      stall_o    = STALL_MEMW;
      flush_o    = FLUSH_MEMW;
      w_next     = ST_MEM_WAIT;
      // Keep the oldest mispredict; a later one is on the wrong path anyway.
      w_latch_br = br_mispredict_i && !r_pend_br;
    end else if ((mdu_start_i && (r_state != ST_MDU_WAIT) && !mdu_done_i) ||
                 ((r_state == ST_MDU_WAIT) && !mdu_done_i)) begin
      stall_o = STALL_MDUW;
      flush_o = FLUSH_MDUW;
      w_next  = ST_MDU_WAIT;
    end else if (br_mispredict_i || r_pend_br) begin
      w_br    = 1'b1;
      stall_o = STALL_BR;
      flush_o = FLUSH_BR;
    end else if (load_use_i) begin
      w_lu    = 1'b1;
      stall_o = STALL_LU;
      flush_o = FLUSH_LU;
    end

    if (w_expire && !w_trap) begin
      w_next = ST_RUN;
      if (r_state == ST_MEM_WAIT) begin
        dmem_abort_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_br     <= 1'b0;
      r_br_tgt      <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_redirect <= w_trap || w_br;
      if (w_trap) begin
        r_redirect_pc <= trap_vec_i;
      end else if (w_br) begin
        r_redirect_pc <= r_pend_br ? r_br_tgt : br_target_i;
      end
      if (w_trap || w_br) begin
        r_pend_br <= 1'b0;
      end else if (w_latch_br) begin
        r_pend_br <= 1'b1;
        r_br_tgt  <= br_target_i;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign timeout_o     = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_lu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_lu    <= '0;
    end else begin
      if ((|stall_o) && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 32'd1;
      if ((w_trap || w_br) && !(&r_perf_flush)) r_perf_flush <= r_perf_flush + 32'd1;
      if (w_lu && !(&r_perf_lu)) r_perf_lu <= r_perf_lu + 32'd1;
    end
  end

  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
  assign perf_lu_o    = r_perf_lu;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int XLEN   = 32;
  localparam int TO_MAX = 200;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            load_use_i, mdu_start_i, mdu_done_i, dmem_req_i, dmem_ready_i;
  logic            br_mispredict_i, trap_i;
  logic [XLEN-1:0] br_target_i, trap_vec_i;
  logic [3:0]      stall_o, flush_o;
  logic            redirect_o, dmem_abort_o, timeout_o;
  logic [XLEN-1:0] redirect_pc_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(XLEN), .TIMEOUT_W(8), .TIMEOUT_MAX(TO_MAX)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .load_use_i     (load_use_i),
    .mdu_start_i    (mdu_start_i),
    .mdu_done_i     (mdu_done_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ready_i   (dmem_ready_i),
    .br_mispredict_i(br_mispredict_i),
    .br_target_i    (br_target_i),
    .trap_i         (trap_i),
    .trap_vec_i     (trap_vec_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .redirect_o     (redirect_o),
    .redirect_pc_o  (redirect_pc_o),
    .dmem_abort_o   (dmem_abort_o),
    .timeout_o      (timeout_o)
  );

  typedef struct {
    string       name;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        abort;
    logic        redir;
    logic [31:0] pc;
    logic        pc_chk;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (stall_o !== e.stall || flush_o !== e.flush || dmem_abort_o !== e.abort ||
            redirect_o !== e.redir || timeout_o !== e.tmo ||
            ((e.pc_chk || e.redir) && redirect_pc_o !== e.pc)) begin
          n_fail++;
          $display("FAIL %s: got stall=%b flush=%b abort=%b redir=%b pc=%h tmo=%b, expected stall=%b flush=%b abort=%b redir=%b pc=%h tmo=%b",
                   e.name, stall_o, flush_o, dmem_abort_o, redirect_o, redirect_pc_o, timeout_o,
                   e.stall, e.flush, e.abort, e.redir, e.pc, e.tmo);
        end
      end
    end
  end

  task automatic clr();
    load_use_i = 0; mdu_start_i = 0; mdu_done_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
    br_mispredict_i = 0; br_target_i = '0; trap_i = 0; trap_vec_i = '0;
  endtask

  task automatic chk(input string name, input logic [3:0] st, input logic [3:0] fl,
                     input logic ab, input logic rd, input logic [31:0] pc,
                     input logic pcc, input logic tmo);
    exp_t x;
    x.name = name; x.stall = st; x.flush = fl; x.abort = ab; x.redir = rd;
    x.pc = pc; x.pc_chk = pcc; x.tmo = tmo;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_n = 0;
    clr();
    tick();

    chk("reset", 4'b0000, 4'b1111, 0, 0, 32'h0, 1, 0); tick();
    reset_n = 1;
    chk("init", 4'b0000, 4'b1111, 0, 0, 32'h0, 1, 0); tick();
    chk("run_idle", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();

    load_use_i = 1;
    chk("load_use", 4'b0011, 4'b0010, 0, 0, 32'h0, 0, 0); tick();
    clr();
    chk("load_use_end", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();

    // Memory wait with a mispredict parked behind it.
    dmem_req_i = 1; br_mispredict_i = 1; br_target_i = 32'h100;
    chk("memw_1", 4'b1111, 4'b1000, 0, 0, 32'h0, 0, 0); tick();
    clr(); dmem_req_i = 1;
    chk("memw_2", 4'b1111, 4'b1000, 0, 0, 32'h0, 0, 0); tick();
    chk("memw_3", 4'b1111, 4'b1000, 0, 0, 32'h0, 0, 0); tick();
    dmem_ready_i = 1;
    chk("memw_release_br", 4'b0000, 4'b0011, 0, 0, 32'h0, 0, 0); tick();
    clr();
    chk("pend_br_redirect", 4'b0000, 4'b0000, 0, 1, 32'h100, 1, 0); tick();
    chk("redirect_once", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();

    mdu_start_i = 1;
    chk("mdu_1", 4'b0111, 4'b0100, 0, 0, 32'h0, 0, 0); tick();
    clr();
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("mdu_%0d", i), 4'b0111, 4'b0100, 0, 0, 32'h0, 0, 0); tick();
    end
    mdu_done_i = 1;
    chk("mdu_done", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();
    mdu_start_i = 1;
    chk("mdu_single_cycle", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();
    clr(); dmem_req_i = 1; dmem_ready_i = 1;
    chk("mem_same_cycle_ready", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();

    // Trap beats a mispredict during MEM_WAIT.
    clr(); dmem_req_i = 1;
    chk("trap_memw", 4'b1111, 4'b1000, 0, 0, 32'h0, 0, 0); tick();
    trap_i = 1; trap_vec_i = 32'h80; br_mispredict_i = 1; br_target_i = 32'h200;
    chk("trap", 4'b0000, 4'b0111, 1, 0, 32'h0, 0, 0); tick();
    clr();
    chk("trap_redirect", 4'b0000, 4'b0000, 0, 1, 32'h80, 1, 0); tick();
    chk("trap_no_br_redirect", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();

    br_mispredict_i = 1; br_target_i = 32'h300; load_use_i = 1;
    chk("br_over_lu", 4'b0000, 4'b0011, 0, 0, 32'h0, 0, 0); tick();
    clr();
    chk("br_redirect", 4'b0000, 4'b0000, 0, 1, 32'h300, 1, 0); tick();

    // Watchdog: RUN entry cycle plus TO_MAX MEM_WAIT cycles, the last one expires.
    dmem_req_i = 1;
    chk("wd_enter", 4'b1111, 4'b1000, 0, 0, 32'h0, 0, 0); tick();
    for (int k = 1; k < TO_MAX; k++) begin
      chk("wd_wait", 4'b1111, 4'b1000, 0, 0, 32'h0, 0, 0); tick();
    end
    chk("wd_expire", 4'b1111, 4'b1000, 1, 0, 32'h0, 0, 0); tick();
    clr();
    chk("wd_timeout_run", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 1); tick();
    chk("wd_timeout_sticky", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 1); tick();

    // Reset mid-operation drops the parked mispredict and the sticky timeout.
    dmem_req_i = 1; br_mispredict_i = 1; br_target_i = 32'h400;
    chk("rst_memw", 4'b1111, 4'b1000, 0, 0, 32'h0, 0, 1); tick();
    clr(); reset_n = 0;
    chk("rst_mid", 4'b0000, 4'b1111, 0, 0, 32'h0, 1, 0); tick();
    reset_n = 1;
    chk("rst_init", 4'b0000, 4'b1111, 0, 0, 32'h0, 1, 0); tick();
    chk("rst_no_redirect", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();
    chk("rst_idle", 4'b0000, 4'b0000, 0, 0, 32'h0, 0, 0); tick();

    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
